pc_irq_ctrl: RTL and testbench
==============================

# pc_irq_ctrl

Program-counter register with a vectored, prioritised interrupt front end. It is the parametrised successor of the single-button interrupt PC. It sits at the fetch stage, taking `next_pc` from the PC-increment/branch logic and driving the instruction-memory address. It supports N interrupt channels, a hardware link stack for optional nesting, and explicit return via `mret`.

## Interface
Parameters:
- `XLEN`, 32: PC width.
- `NUM_IRQ`, 4: interrupt channels, 1..16; channel 0 has the highest priority.
- `STACK_DEPTH`, 2: link-stack entries, ≥1; forced to 1 without nesting.
- `RESET_PC`, 0: PC value after reset.
- `VECTOR_BASE`, 32'h1000_0000: vector of channel 0.
- `VECTOR_STRIDE`, 32'h100: spacing between channel vectors.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `irq_in`, in, NUM_IRQ: raw interrupt requests, asynchronous to `clk`, rising-edge triggered.
- `irq_mask`, in, NUM_IRQ: 1 enables the channel to be taken.
- `mret`, in, 1: return-from-interrupt request from decode.
- `stall`, in, 1: holds the PC and blocks take/return.
- `next_pc`, in, XLEN: sequential/branch target.
- `pc`, out, XLEN: registered PC.
- `in_isr`, out, 1: depth ≠ 0; replaces `iled`.
- `active_id`, out, $clog2(NUM_IRQ) (min 1): channel being serviced; 0 when idle.
- `irq_pending`, out, NUM_IRQ: latched pending bits.
- `depth`, out, $clog2(STACK_DEPTH+1): link-stack occupancy.

## Operation
- Each channel passes through a 2-flop synchroniser and then a rising-edge detector (`s2 & ~s3`). A detected edge sets `irq_pending[i]`. Pending bits latch regardless of mask and stall.
- Winner: the lowest index `i` with `irq_pending[i] & irq_mask[i]`.
- Priority of the per-cycle actions, evaluated only when `!stall`:
  1. `mret && depth>0`: pop the stack. `pc` ← popped PC, `active_id` ← popped id, `depth`−1.
  2. Take: requires a winner `w`, and either `depth==0`, or (nesting enabled, `w < active_id`, and `depth<STACK_DEPTH`). The action:
     - push {`pc`, `active_id`};
     - `pc` ← `VECTOR_BASE + w*VECTOR_STRIDE`, computed modulo 2^XLEN;
     - `active_id` ← `w`, `depth`+1;
     - clear `irq_pending[w]`.
  3. Otherwise `pc` ← `next_pc`. The PC advances normally inside the ISR too.
- `mret` with `depth==0` is ignored; `pc` ← `next_pc`.
- `mret` and a take candidate in the same cycle: `mret` wins. The candidate is re-evaluated on the next edge.
- A new edge on channel `w` in the same cycle as its pending bit is cleared: set wins, and the bit stays 1.
- A pushed PC is the interrupted instruction's address, not `next_pc`.
- The stack can never overflow; the take condition gates on `depth`.
- `stall`: `pc`, stack, `depth` and `active_id` hold. Synchronisers and pending bits continue to update.

## Timing
- Reset values: `pc`=RESET_PC, `depth`=0, `in_isr`=0, `active_id`=0, `irq_pending`=0. Synchronisers and stack are also cleared to 0. Reset asserted mid-ISR discards the whole stack.
- Edge-to-vector latency, with `irq_in` first sampled high at edge E0:
  - `s1` at E0, `s2` at E1;
  - pending set at E2;
  - `pc`=vector after E3, provided mask=1, no stall and no `mret`.
- `irq_in` pulses shorter than one clock may be lost. A level held high produces exactly one pending event.
- Return latency: `mret` high at edge E gives `pc`=popped PC after E.
- All outputs are registered except `in_isr`, which is decoded from `depth`.

## Configuration
- `PC_IRQ_NESTING_EN` defined: preemption by a strictly higher-priority channel is allowed, up to `STACK_DEPTH`.
- `PC_IRQ_NESTING_EN` undefined:
  - the stack collapses to a single link register (effective `STACK_DEPTH`=1);
  - takes occur only when `depth==0`;
  - pending bits still accumulate during the ISR and are taken after `mret`.

## Structure
- Package `pc_irq_pkg` holds:
  - default constants `PC_RESET_DEFAULT` and `IRQ_VECTOR_BASE_DEFAULT`;
  - the stack-entry typedef {pc, id};
  - a function `irq_prio_enc` (lowest set bit → index, plus valid flag).
- Sub-module `irq_sync_edge`: a per-channel 2-flop synchroniser and rising-edge detector, instantiated NUM_IRQ times via generate.

## Test plan
Defaults unless noted: XLEN=32, NUM_IRQ=4, base 0x1000_0000, stride 0x100.
- Reset: `reset` pulsed while `next_pc`=0x40 → `pc`=0, `depth`=0, `irq_pending`=0. After release, `pc` steps through 0x40-driven values.
- Single take: at `pc`=0x20, `irq_in[2]` rises with mask=4'hF → `pc`=0x1000_0200 on E3, `depth`=1, `active_id`=2. `mret` then restores `pc`=0x20 (plus E3 drift) and `depth`=0.
- Simultaneous: `irq_in[3]` and `irq_in[1]` rise together → vector 0x1000_0100 is taken first. After `mret`, 0x1000_0300 is taken on the next cycle.
- Nesting (EN defined): in ISR 3, `irq_in[0]` rises → `depth`=2, `pc`=0x1000_0000. Two `mret`s unwind to ISR 3 and then the original PC. Without the macro: ISR 0 runs only after the first `mret`.
- Mask/stall: `irq_mask[1]`=0 with `irq_in[1]` rising → pending=4'b0010 and no take. The mask is then set while `stall`=1 → `pc` holds. `stall` is released → vector 0x1000_0100.
- Edge cases:
  - `mret` at `depth`=0 → `pc`=`next_pc`.
  - `mret` in the same cycle as a pending take → pop first, take one cycle later.
  - `reset` asserted at `depth`=2 → everything returns to its reset values.

Source files
------------

// File: rtl/pc_irq_pkg.sv
// Shared constants, stack-entry type and priority encoder for the vectored-interrupt PC.
package pc_irq_pkg;

  localparam int unsigned PC_MAX_W = 64;
  localparam int unsigned ID_MAX_W = 4;

  localparam logic [31:0] PC_RESET_DEFAULT        = '0;
  localparam logic [31:0] IRQ_VECTOR_BASE_DEFAULT = 32'h1000_0000;

  // Sized for the widest supported PC and channel count; users slice down.
  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [ID_MAX_W-1:0] id;
  } irq_stack_entry_t;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] idx;
  } irq_prio_t;

  function automatic irq_prio_t irq_prio_enc(input logic [15:0] req);
    irq_prio_t r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (req[i] && !r.valid) begin
        r.valid = 1'b1;
        r.idx   = ID_MAX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_irq_ctrl_if.sv
// Fetch-stage bus of pc_irq_ctrl: interrupt inputs, decode controls and PC outputs.
interface pc_irq_ctrl_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned STACK_DEPTH = 2
);
  localparam int unsigned ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [NUM_IRQ-1:0] irq_in;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               mret;
  logic               stall;
  logic [XLEN-1:0]    next_pc;
  logic [XLEN-1:0]    pc;
  logic               in_isr;
  logic [ID_W-1:0]    active_id;
  logic [NUM_IRQ-1:0] irq_pending;
  logic [DEPTH_W-1:0] depth;

  modport master (
    output irq_in, irq_mask, mret, stall, next_pc,
    input  pc, in_isr, active_id, irq_pending, depth
  );

  modport slave (
    input  irq_in, irq_mask, mret, stall, next_pc,
    output pc, in_isr, active_id, irq_pending, depth
  );
endinterface

// File: rtl/pc_irq_ctrl_sync_edge.sv
// Per-channel 2-flop synchroniser followed by a rising-edge detector.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic irq_i,
  output logic edge_o
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= irq_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_o = s2_q & ~s3_q;
endmodule

// File: rtl/pc_irq_ctrl.sv
// Program counter with vectored, prioritised interrupts and a link stack.
// Nesting (preemption by a higher-priority channel) is enabled by defining PC_IRQ_NESTING_EN.
module pc_irq_ctrl
  import pc_irq_pkg::*;
#(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     NUM_IRQ       = 4,
  parameter int unsigned     STACK_DEPTH   = 2,
  parameter logic [XLEN-1:0] RESET_PC      = XLEN'(PC_RESET_DEFAULT),
  parameter logic [XLEN-1:0] VECTOR_BASE   = XLEN'(IRQ_VECTOR_BASE_DEFAULT),
  parameter logic [XLEN-1:0] VECTOR_STRIDE = XLEN'(32'h100)
) (
  input  logic             clk,
  input  logic             reset,
  pc_irq_ctrl_if.slave     bus
);
  localparam int unsigned ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
`ifdef PC_IRQ_NESTING_EN
  localparam bit          NEST_EN   = 1'b1;
  localparam int unsigned EFF_DEPTH = STACK_DEPTH;
`else
  localparam bit          NEST_EN   = 1'b0;
  localparam int unsigned EFF_DEPTH = 1;
`endif

  logic [NUM_IRQ-1:0] edge_det;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d, pend_clr;
  irq_stack_entry_t   stk_q [EFF_DEPTH];
  irq_stack_entry_t   stk_d [EFF_DEPTH];
  irq_stack_entry_t   pop_entry;
  irq_prio_t          win;
  logic               do_pop, can_take;
  logic               unused_pop_bits;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk    (clk),
      .reset  (reset),
      .irq_i  (bus.irq_in[g]),
      .edge_o (edge_det[g])
    );
  end

  always_comb begin
    win = irq_prio_enc(16'(pend_q & bus.irq_mask));
    pop_entry = '0;
    for (int unsigned i = 0; i < EFF_DEPTH; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) pop_entry = stk_q[i];
    end
    do_pop   = bus.mret && (depth_q != '0);
    can_take = win.valid && ((depth_q == '0) ||
               (NEST_EN && (win.idx < ID_MAX_W'(id_q)) && (depth_q < DEPTH_W'(EFF_DEPTH))));

    pc_d     = pc_q;
    id_d     = id_q;
    depth_d  = depth_q;
    stk_d    = stk_q;
    pend_clr = '0;
    if (!bus.stall) begin
      if (do_pop) begin
        pc_d    = pop_entry.pc[XLEN-1:0];
        id_d    = pop_entry.id[ID_W-1:0];
        depth_d = depth_q - DEPTH_W'(1);
      end else if (can_take) begin
        for (int unsigned i = 0; i < EFF_DEPTH; i++) begin
          if (depth_q == DEPTH_W'(i)) begin
            stk_d[i].pc = PC_MAX_W'(pc_q);
            stk_d[i].id = ID_MAX_W'(id_q);
          end
        end
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
          if (win.idx == ID_MAX_W'(i)) pend_clr[i] = 1'b1;
        end
        pc_d    = VECTOR_BASE + XLEN'(win.idx) * VECTOR_STRIDE;
        id_d    = win.idx[ID_W-1:0];
        depth_d = depth_q + DEPTH_W'(1);
      end else begin
        pc_d = bus.next_pc;
      end
    end
    // A fresh edge overrides the clear of the channel just taken.
    pend_d = (pend_q & ~pend_clr) | edge_det;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      id_q    <= '0;
      depth_q <= '0;
      pend_q  <= '0;
      for (int unsigned i = 0; i < EFF_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      id_q    <= id_d;
      depth_q <= depth_d;
      pend_q  <= pend_d;
      stk_q   <= stk_d;
    end
  end

  assign unused_pop_bits = ^pop_entry;

  assign bus.pc          = pc_q;
  assign bus.active_id   = id_q;
  assign bus.depth       = depth_q;
  assign bus.irq_pending = pend_q;
  assign bus.in_isr      = (depth_q != '0);
endmodule

// File: tb/tb_pc_irq_ctrl.sv
// Randomised and directed bench for pc_irq_ctrl against a queue-based reference model.
module tb_pc_irq_ctrl;
  localparam int NIRQ = 4;
  localparam int SD   = 2;
`ifdef PC_IRQ_NESTING_EN
  localparam bit NEST = 1'b1;
  localparam int EFF  = SD;
`else
  localparam bit NEST = 1'b0;
  localparam int EFF  = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_irq_ctrl_if #(.XLEN(32), .NUM_IRQ(NIRQ), .STACK_DEPTH(SD)) bus ();

  pc_irq_ctrl #(
    .XLEN(32), .NUM_IRQ(NIRQ), .STACK_DEPTH(SD), .RESET_PC(32'h0),
    .VECTOR_BASE(32'h1000_0000), .VECTOR_STRIDE(32'h100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: link stack as a queue, sample history of irq_in per edge.
  typedef struct { logic [31:0] pc; int id; } ent_t;
  ent_t        stk[$];
  logic [31:0] m_pc;
  int          m_act;
  logic [3:0]  m_pend, h1, h2, h3;

  task automatic model_reset();
    m_pc = '0; m_act = 0; stk.delete();
    m_pend = '0; h1 = '0; h2 = '0; h3 = '0;
  endtask

  task automatic model_edge();
    logic [3:0] det;
    int         w;
    ent_t       e;
    det = h2 & ~h3;
    w = -1;
    for (int i = NIRQ - 1; i >= 0; i--) if (m_pend[i] && bus.irq_mask[i]) w = i;
    if (!bus.stall) begin
      if (bus.mret && stk.size() > 0) begin
        e = stk.pop_back();
        m_pc = e.pc; m_act = e.id;
      end else if (w >= 0 && (stk.size() == 0 || (NEST && w < m_act && stk.size() < EFF))) begin
        e.pc = m_pc; e.id = m_act;
        stk.push_back(e);
        m_pc = 32'h1000_0000 + 32'(w) * 32'h100;
        m_act = w;
        m_pend[w] = 1'b0;
      end else begin
        m_pc = bus.next_pc;
      end
    end
    m_pend = m_pend | det;
    h3 = h2; h2 = h1; h1 = bus.irq_in;
  endtask

  task automatic check_outputs();
    check("pc", bus.pc, m_pc);
    check("depth", bus.depth, stk.size());
    check("active_id", bus.active_id, m_act);
    check("irq_pending", bus.irq_pending, m_pend);
    check("in_isr", bus.in_isr, stk.size() != 0);
  endtask

  task automatic drive(input logic [3:0] irq, input logic [3:0] mask, input logic mr, input logic st);
    bus.irq_in = irq; bus.irq_mask = mask; bus.mret = mr; bus.stall = st;
    bus.next_pc = m_pc + 32'd4;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
  endtask

  logic [31:0] held_pc;
  logic [3:0]  r_irq, r_mask;

  initial begin
    reset = 1'b1;
    bus.irq_in = '0; bus.irq_mask = 4'hF; bus.mret = 1'b0; bus.stall = 1'b0;
    bus.next_pc = 32'h40;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_pc", bus.pc, 32'h0);
    check_outputs();
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("pc_next", bus.pc, 32'h40);
      check_outputs();
    end

    // Single take on channel 2, then return.
    repeat (3) drive(4'b0000, 4'hF, 1'b0, 1'b0);
    repeat (3) drive(4'b0100, 4'hF, 1'b0, 1'b0);
    check("pend2_set", bus.irq_pending, 4'b0100);
    drive(4'b0100, 4'hF, 1'b0, 1'b0);
    check("vec2", bus.pc, 32'h1000_0200);
    check("act2", bus.active_id, 2);
    repeat (2) drive(4'b0100, 4'hF, 1'b0, 1'b0);
    drive(4'b0000, 4'hF, 1'b1, 1'b0);
    check("ret_depth", bus.depth, 0);
    repeat (3) drive(4'b0000, 4'hF, 1'b0, 1'b0);

    // Simultaneous channels 3 and 1: 1 first, 3 right after mret.
    repeat (4) drive(4'b1010, 4'hF, 1'b0, 1'b0);
    check("vec1_first", bus.pc, 32'h1000_0100);
    repeat (2) drive(4'b1010, 4'hF, 1'b0, 1'b0);
    drive(4'b0000, 4'hF, 1'b1, 1'b0);
    check("pop_before_take", bus.depth, 0);
    drive(4'b0000, 4'hF, 1'b0, 1'b0);
    check("vec3_after", bus.pc, 32'h1000_0300);
    drive(4'b0000, 4'hF, 1'b1, 1'b0);
    repeat (3) drive(4'b0000, 4'hF, 1'b0, 1'b0);

    // Channel 0 arriving inside ISR 3.
    repeat (4) drive(4'b1000, 4'hF, 1'b0, 1'b0);
    repeat (4) drive(4'b1001, 4'hF, 1'b0, 1'b0);
    check("nest_depth", bus.depth, NEST ? 2 : 1);
    drive(4'b1001, 4'hF, 1'b1, 1'b0);
    drive(4'b1001, 4'hF, 1'b0, 1'b0);
    drive(4'b1001, 4'hF, 1'b1, 1'b0);
    check("unwound", bus.depth, 0);
    repeat (3) drive(4'b0000, 4'hF, 1'b0, 1'b0);

    // Masked channel 1, unmasked under stall, then released.
    repeat (4) drive(4'b0010, 4'b1101, 1'b0, 1'b0);
    check("masked_pend", bus.irq_pending, 4'b0010);
    check("masked_depth", bus.depth, 0);
    held_pc = bus.pc;
    repeat (3) drive(4'b0010, 4'hF, 1'b0, 1'b1);
    check("stall_hold", bus.pc, held_pc);
    drive(4'b0010, 4'hF, 1'b0, 1'b0);
    check("vec1_release", bus.pc, 32'h1000_0100);
    drive(4'b0000, 4'hF, 1'b1, 1'b0);

    // mret with nothing to return from.
    repeat (2) drive(4'b0000, 4'hF, 1'b1, 1'b0);
    check("mret_idle_depth", bus.depth, 0);

    // Reset in the middle of a (possibly nested) ISR.
    repeat (4) drive(4'b1000, 4'hF, 1'b0, 1'b0);
    repeat (4) drive(4'b1001, 4'hF, 1'b0, 1'b0);
    pulse_reset();
    check("reset_mid_isr", bus.depth, 0);
    repeat (3) drive(4'b0000, 4'hF, 1'b0, 1'b0);

    // Random traffic.
    r_irq = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NIRQ; b++) if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
      r_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 149) == 0) pulse_reset();
      else drive(r_irq, r_mask, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
